// File: rtl/load_align_unit.sv
// Sequenced load unit: issues word-aligned reads, splits boundary-crossing loads
// into two beats, and returns the extracted, sign/zero-extended result over a handshake.

module load_align_lane #(
  parameter int LANE = 0
) (
  input  logic [7:0] byte_in,
  input  logic [3:0] size_bytes,
  input  logic       fill,
  output logic [7:0] byte_out
);
  localparam logic [3:0] LANE_IDX = 4'(LANE);

  // Lanes beyond the access size carry the extension fill.
  assign byte_out = (LANE_IDX < size_bytes) ? byte_in : {8{fill}};
endmodule

module load_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault
);
  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(B);

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [4:0]        rd;
  } req_t;

  state_t          state, state_nxt;
  req_t            cap_q;
  logic            cross_q;
  logic [XLEN-1:0] lo_q;

  // Request decode, evaluated on the incoming request in IDLE
  logic [OFF_W-1:0] in_off;
  logic [4:0]       in_size;
  logic             in_cross, in_illegal, in_fault;

  assign in_off     = req_addr[OFF_W-1:0];
  assign in_size    = 5'd1 << req_funct3[1:0];
  assign in_cross   = (5'(in_off) + in_size) > 5'(B);
  assign in_illegal = (req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
  assign in_fault   = in_illegal || (in_cross && !MISALIGN_EN);

  logic [ADDR_W-1:0] addr_aligned;
  assign addr_aligned = {cap_q.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_nxt = in_fault ? RESP : RD0;
      end
      RD0: begin
        mem_req  = 1'b1;
        mem_addr = addr_aligned;
        if (mem_gnt) state_nxt = WAIT0;
      end
      WAIT0: if (mem_rvalid) state_nxt = cross_q ? RD1 : RESP;
      RD1: begin
        mem_req  = 1'b1;
        mem_addr = addr_aligned + STRIDE;
        if (mem_gnt) state_nxt = WAIT1;
      end
      WAIT1: if (mem_rvalid) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Extraction: the second beat supplies the high word; single beat uses zero.
  logic [XLEN-1:0]  lo_sel, hi_sel, shifted, ext;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       size_q;
  logic             sign_bit, fill;

  assign lo_sel  = (state == WAIT1) ? lo_q : mem_rdata;
  assign hi_sel  = (state == WAIT1) ? mem_rdata : '0;
  assign off_q   = cap_q.addr[OFF_W-1:0];
  assign size_q  = 4'd1 << cap_q.funct3[1:0];
  assign shifted = XLEN'({hi_sel, lo_sel} >> {off_q, 3'b000});

  always_comb begin
    sign_bit = shifted[7];
    case (cap_q.funct3[1:0])
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      default: sign_bit = shifted[31];
    endcase
  end

  assign fill = !cap_q.funct3[2] && sign_bit;

  for (genvar j = 0; j < B; j++) begin : g_lane
    load_align_lane #(.LANE(j)) u_lane (
      .byte_in   (shifted[8*j +: 8]),
      .size_bytes(size_q),
      .fill      (fill),
      .byte_out  (ext[8*j +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= '0;
      cross_q   <= 1'b0;
      lo_q      <= '0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_q   <= '{addr: req_addr, funct3: req_funct3, rd: req_rd};
          cross_q <= in_cross;
          if (in_fault) begin
            rsp_data  <= '0;
            rsp_rd    <= req_rd;
            rsp_fault <= 1'b1;
          end
        end
        WAIT0: if (mem_rvalid) begin
          lo_q <= mem_rdata;
          if (!cross_q) begin
            rsp_data  <= ext;
            rsp_rd    <= cap_q.rd;
            rsp_fault <= 1'b0;
          end
        end
        WAIT1: if (mem_rvalid) begin
          rsp_data  <= ext;
          rsp_rd    <= cap_q.rd;
          rsp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench: three instances (32-bit split, 32-bit fault-on-misalign, 64-bit)
// each served by a small memory responder with programmable grant delay.

module tb_load_align_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      = 1'b0;
  logic [31:0] req_addr   = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd     = '0;
  logic        rsp_ready  = 1'b1;
  int          gnt_delay  = 0;
  int          vectors    = 0;
  int          miscompares = 0;

  // ---- instance a: XLEN=32, MISALIGN_EN=1
  logic        req_valid_a = 1'b0, req_ready_a, mem_req_a, mem_gnt_a, mem_rvalid_a;
  logic        rsp_valid_a, rsp_fault_a, inj_a = 1'b0, rv_a = 1'b0;
  logic [31:0] mem_addr_a, rdat_a = '0, rsp_data_a;
  logic [4:0]  rsp_rd_a;
  int          gwait_a = 0, ng_a = 0;
  logic [31:0] gaddr_a [0:7];

  // ---- instance n: XLEN=32, MISALIGN_EN=0
  logic        req_valid_n = 1'b0, req_ready_n, mem_req_n, mem_gnt_n, rsp_valid_n, rsp_fault_n, rv_n = 1'b0;
  logic [31:0] mem_addr_n, rdat_n = '0, rsp_data_n;
  logic [4:0]  rsp_rd_n;
  int          gwait_n = 0, ng_n = 0;

  // ---- instance w: XLEN=64, MISALIGN_EN=1
  logic        req_valid_w = 1'b0, req_ready_w, mem_req_w, mem_gnt_w, rsp_valid_w, rsp_fault_w, rv_w = 1'b0;
  logic [31:0] mem_addr_w;
  logic [63:0] rdat_w = '0, rsp_data_w;
  logic [4:0]  rsp_rd_w;
  int          gwait_w = 0, ng_w = 0;
  logic [31:0] gaddr_w [0:7];

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req_a), .mem_gnt(mem_gnt_a), .mem_addr(mem_addr_a),
    .mem_rvalid(mem_rvalid_a), .mem_rdata(rdat_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
    .rsp_rd(rsp_rd_a), .rsp_fault(rsp_fault_a));

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req_n), .mem_gnt(mem_gnt_n), .mem_addr(mem_addr_n),
    .mem_rvalid(rv_n), .mem_rdata(rdat_n),
    .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready), .rsp_data(rsp_data_n),
    .rsp_rd(rsp_rd_n), .rsp_fault(rsp_fault_n));

  load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req_w), .mem_gnt(mem_gnt_w), .mem_addr(mem_addr_w),
    .mem_rvalid(rv_w), .mem_rdata(rdat_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w),
    .rsp_rd(rsp_rd_w), .rsp_fault(rsp_fault_w));

  function automatic logic [31:0] m32(input logic [31:0] a);
    case (a)
      32'h100: return 32'h80FF7F01;
      32'h104: return 32'h44332211;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] m64(input logic [31:0] a);
    case (a)
      32'h200: return 64'h0123456789ABCDEF;
      32'h208: return 64'h00000000FFFFFFFF;
      default: return 64'h0;
    endcase
  endfunction

  // Memory responders: grant after gnt_delay cycles of mem_req, data one cycle later.
  assign mem_gnt_a    = mem_req_a && (gwait_a >= gnt_delay);
  assign mem_gnt_n    = mem_req_n && (gwait_n >= gnt_delay);
  assign mem_gnt_w    = mem_req_w && (gwait_w >= gnt_delay);
  assign mem_rvalid_a = rv_a | inj_a;

  always @(posedge clk) begin
    rv_a    <= 1'b0;
    gwait_a <= (mem_req_a && !mem_gnt_a) ? gwait_a + 1 : 0;
    if (mem_gnt_a) begin
      rv_a <= 1'b1;
      rdat_a <= m32(mem_addr_a);
      gaddr_a[ng_a % 8] <= mem_addr_a;
      ng_a <= ng_a + 1;
    end
  end

  always @(posedge clk) begin
    rv_n    <= 1'b0;
    gwait_n <= (mem_req_n && !mem_gnt_n) ? gwait_n + 1 : 0;
    if (mem_gnt_n) begin
      rv_n <= 1'b1;
      rdat_n <= m32(mem_addr_n);
      ng_n <= ng_n + 1;
    end
  end

  always @(posedge clk) begin
    rv_w    <= 1'b0;
    gwait_w <= (mem_req_w && !mem_gnt_w) ? gwait_w + 1 : 0;
    if (mem_gnt_w) begin
      rv_w <= 1'b1;
      rdat_w <= m64(mem_addr_w);
      gaddr_w[ng_w % 8] <= mem_addr_w;
      ng_w <= ng_w + 1;
    end
  end

  function automatic logic f_ready(input int w);
    case (w) 0: return req_ready_a; 1: return req_ready_n; default: return req_ready_w; endcase
  endfunction
  function automatic logic f_valid(input int w);
    case (w) 0: return rsp_valid_a; 1: return rsp_valid_n; default: return rsp_valid_w; endcase
  endfunction
  function automatic logic f_fault(input int w);
    case (w) 0: return rsp_fault_a; 1: return rsp_fault_n; default: return rsp_fault_w; endcase
  endfunction
  function automatic logic [4:0] f_rd(input int w);
    case (w) 0: return rsp_rd_a; 1: return rsp_rd_n; default: return rsp_rd_w; endcase
  endfunction
  function automatic logic [63:0] f_data(input int w);
    case (w) 0: return {32'h0, rsp_data_a}; 1: return {32'h0, rsp_data_n}; default: return rsp_data_w; endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int w, input logic v);
    case (w) 0: req_valid_a = v; 1: req_valid_n = v; default: req_valid_w = v; endcase
  endtask

  // Starts and ends on a falling edge; returns in cycle 1 after the accept edge.
  task automatic issue(input int w, input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    chk("req_ready_idle", 64'(f_ready(w)), 64'd1);
    req_addr = addr; req_funct3 = f3; req_rd = rd;
    set_valid(w, 1'b1);
    @(negedge clk);
    set_valid(w, 1'b0);
  endtask

  task automatic expect_rsp(input int w, input string tag, input int lat, input logic [63:0] data,
                            input logic [4:0] rd, input logic fault, input bit take);
    int cyc = 1;
    while (!f_valid(w) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(lat));
    chk({tag, ".data"}, f_data(w), data);
    chk({tag, ".rd"}, 64'(f_rd(w)), 64'(rd));
    chk({tag, ".fault"}, 64'(f_fault(w)), 64'(fault));
    if (take) @(negedge clk);
  endtask

  logic [2:0]  f3v  [0:3] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] expv [0:3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF};

  initial begin
    int n0;
    // reset state
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready_a), 64'd0);
    chk("rst.mem_req", 64'(mem_req_a), 64'd0);
    chk("rst.mem_addr", 64'(mem_addr_a), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid_a), 64'd0);
    chk("rst.rsp_data", 64'(rsp_data_a), 64'd0);
    chk("rst.rsp_rd_fault", {rsp_rd_a, rsp_fault_a}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // byte/half loads at offset 2
    for (int i = 0; i < 4; i++) begin
      n0 = ng_a;
      issue(0, 32'h102, f3v[i], 5'(i + 5));
      expect_rsp(0, "sub_word", 3, {32'h0, expv[i]}, 5'(i + 5), 1'b0, 1'b1);
      chk("sub_word.grants", 64'(ng_a - n0), 64'd1);
      chk("sub_word.addr", 64'(gaddr_a[n0 % 8]), 64'h100);
    end

    // boundary-crossing word load split into two beats
    n0 = ng_a;
    issue(0, 32'h103, 3'b010, 5'd9);
    expect_rsp(0, "cross", 5, 64'h33221180, 5'd9, 1'b0, 1'b1);
    chk("cross.grants", 64'(ng_a - n0), 64'd2);
    chk("cross.addr0", 64'(gaddr_a[n0 % 8]), 64'h100);
    chk("cross.addr1", 64'(gaddr_a[(n0 + 1) % 8]), 64'h104);

    // same load faults when splitting is disabled
    n0 = ng_n;
    issue(1, 32'h103, 3'b010, 5'd10);
    expect_rsp(1, "nomis", 1, 64'h0, 5'd10, 1'b1, 1'b1);
    chk("nomis.grants", 64'(ng_n - n0), 64'd0);

    // illegal funct3
    n0 = ng_a;
    issue(0, 32'h100, 3'b111, 5'd11);
    expect_rsp(0, "f3_111", 1, 64'h0, 5'd11, 1'b1, 1'b1);
    issue(0, 32'h100, 3'b011, 5'd12);
    expect_rsp(0, "f3_011", 1, 64'h0, 5'd12, 1'b1, 1'b1);
    chk("illegal.grants", 64'(ng_a - n0), 64'd0);

    // response back-pressure; a competing request must wait
    rsp_ready = 1'b0;
    n0 = ng_a;
    issue(0, 32'h100, 3'b010, 5'd3);
    expect_rsp(0, "hold", 3, 64'h80FF7F01, 5'd3, 1'b0, 1'b0);
    req_addr = 32'h104; req_funct3 = 3'b100; req_rd = 5'd7;
    req_valid_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold.valid", 64'(rsp_valid_a), 64'd1);
      chk("hold.data", 64'(rsp_data_a), 64'h80FF7F01);
      chk("hold.rd", 64'(rsp_rd_a), 64'd3);
      chk("hold.req_ready", 64'(req_ready_a), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold.released_ready", 64'(req_ready_a), 64'd1);
    chk("hold.released_valid", 64'(rsp_valid_a), 64'd0);
    chk("hold.grants", 64'(ng_a - n0), 64'd1);
    @(negedge clk);
    req_valid_a = 1'b0;
    expect_rsp(0, "after_hold", 3, 64'h11, 5'd7, 1'b0, 1'b1);

    // delayed grant: request and address held steady
    gnt_delay = 4;
    issue(0, 32'h104, 3'b010, 5'd4);
    for (int k = 0; k < 4; k++) begin
      chk("gnt_wait.mem_req", 64'(mem_req_a), 64'd1);
      chk("gnt_wait.mem_addr", 64'(mem_addr_a), 64'h104);
      chk("gnt_wait.no_gnt", 64'(mem_gnt_a), 64'd0);
      @(negedge clk);
    end
    chk("gnt_wait.gnt", 64'(mem_gnt_a), 64'd1);
    expect_rsp(0, "gnt_wait", 3, 64'h44332211, 5'd4, 1'b0, 1'b1);
    gnt_delay = 0;

    // reset while waiting for data, then a stale rvalid after release
    issue(0, 32'h100, 3'b010, 5'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.rsp_valid", 64'(rsp_valid_a), 64'd0);
    chk("midrst.mem_req", 64'(mem_req_a), 64'd0);
    chk("midrst.req_ready", 64'(req_ready_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_a = 1'b1;
    @(negedge clk);
    inj_a = 1'b0;
    chk("stale.rsp_valid", 64'(rsp_valid_a), 64'd0);
    chk("stale.mem_req", 64'(mem_req_a), 64'd0);
    chk("stale.req_ready", 64'(req_ready_a), 64'd1);
    @(negedge clk);
    chk("stale.rsp_valid2", 64'(rsp_valid_a), 64'd0);
    issue(0, 32'h100, 3'b010, 5'd2);
    expect_rsp(0, "post_rst", 3, 64'h80FF7F01, 5'd2, 1'b0, 1'b1);

    // 64-bit datapath
    issue(2, 32'h200, 3'b011, 5'd20);
    expect_rsp(2, "ld", 3, 64'h0123456789ABCDEF, 5'd20, 1'b0, 1'b1);
    issue(2, 32'h208, 3'b110, 5'd21);
    expect_rsp(2, "lwu", 3, 64'h00000000FFFFFFFF, 5'd21, 1'b0, 1'b1);
    n0 = ng_w;
    issue(2, 32'h208, 3'b010, 5'd22);
    expect_rsp(2, "lw64", 3, 64'hFFFFFFFFFFFFFFFF, 5'd22, 1'b0, 1'b1);
    chk("lw64.addr", 64'(gaddr_w[n0 % 8]), 64'h208);
    issue(2, 32'h206, 3'b101, 5'd23);
    expect_rsp(2, "lhu64", 3, 64'h0123, 5'd23, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load unit that replaces the purely combinational byte/half/word load masking with a sequenced, handshaked block.
- Accepts load requests (address, funct3, destination tag) and issues word-aligned reads to data memory.
- Splits a misaligned access that crosses a word boundary into two reads when enabled.
- Extracts and sign- or zero-extends the result, then returns it to writeback over a valid/ready handshake.
- Sits between the execute stage and the data memory port.

Parameters:
- XLEN, 32, data and memory-bus width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split boundary-crossing loads into two beats; 0 = report a fault instead.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_funct3  in  3  RISC-V load funct3.
- req_rd  in  5  destination register tag.
- mem_req  out  1  memory read request.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_addr  out  ADDR_W  word-aligned read address.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt; responses are in order.
- mem_rdata  in  XLEN  read word.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  XLEN  extended load result.
- rsp_rd  out  5  tag echoed from the request.
- rsp_fault  out  1  misaligned access (MISALIGN_EN=0) or illegal funct3.

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=0 while rst_n is low, 1 in IDLE after release; mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_fault=0; capture registers cleared.
- B = XLEN/8; offset = addr[log2(B)-1:0]; size = 1 << funct3[1:0] bytes; funct3[2] = unsigned.
- Illegal funct3: 111 always; 011 and 110 when XLEN=32.
- Crossing: offset + size > B.
- States: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, capture addr/funct3/rd.
  - If illegal, or crossing with MISALIGN_EN=0 -> RESP with rsp_fault=1, rsp_data=0. No memory access.
  - Otherwise -> RD0.
- RD0: mem_req=1, mem_addr = addr with low log2(B) bits cleared; hold both until mem_gnt -> WAIT0.
- WAIT0: on mem_rvalid, capture lo word -> RD1 if crossing, else RESP.
- RD1: mem_req=1, mem_addr = aligned addr + B (wraps modulo 2^ADDR_W); on mem_gnt -> WAIT1.
- WAIT1: on mem_rvalid, capture hi word -> RESP.
- RESP: rsp_valid=1; rsp_data/rsp_rd/rsp_fault registered and stable while rsp_ready=0. On rsp_ready -> IDLE.
- No request accepted in the RESP cycle; one load in flight at a time.
- Extraction: form {hi, lo} (hi=0 when single beat), shift right by offset*8, take the low size bytes.
  - Signed: replicate the top extracted bit to XLEN.
  - Unsigned: zero-fill.
  - Size = XLEN: no extension.
- Latency, gnt same cycle as mem_req and rvalid 1 cycle later:
  - Aligned: accept at cycle 0, rsp_valid at cycle 3.
  - Crossing: rsp_valid at cycle 5.
  - Fault: rsp_valid at cycle 1.
- Ignored inputs:
  - mem_rvalid outside WAIT0/WAIT1 is ignored; this covers stale responses after reset.
  - mem_gnt while mem_req=0 is ignored.
  - Request inputs are ignored when req_ready=0.
- Reset mid-operation: return to IDLE immediately and drop all capture state.

Test Plan:
- XLEN=32, mem[0x100]=0x80FF7F01.
  - lb 0x102 -> rsp_data 0xFFFFFFFF.
  - lbu 0x102 -> 0x000000FF.
  - lh 0x102 -> 0xFFFF80FF.
  - lhu 0x102 -> 0x000080FF.
  - Each case: exactly one mem_req at mem_addr 0x100; rsp_valid 3 cycles after accept (gnt same cycle, rvalid next cycle).
- MISALIGN_EN=1, mem[0x104]=0x44332211, lw 0x103:
  - mem_req at 0x100, then at 0x104.
  - rsp_data 0x33221180, rsp_rd echoed, rsp_fault=0.
- MISALIGN_EN=0, lw 0x103:
  - No mem_req.
  - rsp_valid at cycle 1 with rsp_fault=1, rsp_data 0.
- funct3=111 and (XLEN=32) funct3=011 -> rsp_fault=1, no memory access.
- rsp_ready held low 3 cycles in RESP:
  - rsp_data/rsp_rd constant, req_ready=0, second req_valid not accepted.
  - Accepted only after the response is taken.
- mem_gnt delayed 4 cycles: mem_req and mem_addr held steady throughout.
- Reset during WAIT0, then stale mem_rvalid one cycle after release:
  - Ignored; rsp_valid stays 0.
  - A following lw 0x100 returns 0x80FF7F01.
- XLEN=64:
  - ld at offset 0 -> full word.
  - lwu of 0xFFFFFFFF -> 0x00000000FFFFFFFF.
  - lw of 0xFFFFFFFF -> all ones.
